// File: rtl/crc_stream_engine_pkg.sv
// Shared types and helpers for the streaming CRC engine: FSM state encoding,
// bit-reflection functions and elaboration-time parameter legality check.
package crc_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } crc_state_e;

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [31:0] reflect_n(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    logic [4:0]  idx;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if (i < n) begin
        idx  = 5'(n - 32'd1 - i);
        r[i] = v[idx];
      end
    end
    return r;
  endfunction

  function automatic bit params_ok(input int w, input int dw, input int bpc);
    return ((dw % 32'sd8) == 32'sd0) && (bpc > 32'sd0) && ((dw % bpc) == 32'sd0) &&
           (w >= 32'sd8) && (w <= 32'sd32);
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Message-word input stream and CRC result stream of the CRC engine.
// master = packet source / result consumer, slave = engine.
interface crc_stream_engine_if #(
  parameter int W  = 32,
  parameter int DW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_crc;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_crc
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_crc
  );
endinterface

// File: rtl/crc_step_unit.sv
// Combinational CRC advance by BPC message bits, MSB (bits[BPC-1]) first;
// the x^W term of the polynomial is implicit.
module crc_step_unit #(
  parameter int W   = 32,
  parameter int BPC = 8
) (
  input  logic [W-1:0]   crc_in,
  input  logic [W-1:0]   poly,
  input  logic [BPC-1:0] bits,
  output logic [W-1:0]   crc_out
);

  logic [W-1:0] acc_s;
  logic         fb_s;

  // Unrolled serial LFSR, one iteration per message bit
  always_comb begin
    acc_s = crc_in;
    fb_s  = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb_s  = acc_s[W-1] ^ bits[i];
      acc_s = {acc_s[W-2:0], 1'b0} ^ (fb_s ? poly : {W{1'b0}});
    end
    crc_out = acc_s;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts multi-word frames on a valid/ready stream,
// advances the CRC BPC bits per clock and returns the final CRC on a result port.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int W   = 32,
  parameter int DW  = 32,
  parameter int BPC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         cfg_poly,
  input  logic [W-1:0]         cfg_init,
  input  logic [W-1:0]         cfg_xorout,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
  crc_stream_engine_if.slave   bus,
  output logic                 busy
);

  localparam int STEPS = DW / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  if (!params_ok(W, DW, BPC)) begin : g_bad_params
    $error("crc_stream_engine: illegal W/DW/BPC combination");
  end

  crc_state_e    state_r, next_s;
  logic [W-1:0]  crc_r, poly_r, xorout_r, m_crc_r;
  logic [DW-1:0] sh_r, word_s;
  logic [CW-1:0] cnt_r;
  logic          last_r, refin_r, refout_r;
  logic          s_ready_r, m_valid_r, busy_r;
  logic          s_ready_nx_s, m_valid_nx_s, busy_nx_s;
  logic          accept_s, in_refin_s;
  logic [W-1:0]  step_crc_s, refl_s, final_s;

  // s_ready is only raised in IDLE/WAIT, so it alone qualifies the handshake
  assign accept_s   = bus.s_valid & s_ready_r;
  assign in_refin_s = (state_r == ST_IDLE) ? cfg_refin : refin_r;
  assign refl_s     = W'(reflect_n(32'(crc_r), W));
  assign final_s    = (refout_r ? refl_s : crc_r) ^ xorout_r;

  crc_step_unit #(.W(W), .BPC(BPC)) u_step (
    .crc_in  (crc_r),
    .poly    (poly_r),
    .bits    (sh_r[DW-1 -: BPC]),
    .crc_out (step_crc_s)
  );

  // Incoming word with each byte optionally bit-reflected
  always_comb begin
    word_s = bus.s_data;
    for (int b = 0; b < DW / 8; b++) begin
      if (in_refin_s) begin
        word_s[8*b +: 8] = reflect8(bus.s_data[8*b +: 8]);
      end else begin
        word_s[8*b +: 8] = bus.s_data[8*b +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_s = ST_SHIFT;
        else          next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_r == LAST_CNT) next_s = last_r ? ST_FINAL : ST_WAIT;
        else                   next_s = ST_SHIFT;
      end
      ST_WAIT: begin
        if (accept_s) next_s = ST_SHIFT;
        else          next_s = ST_WAIT;
      end
      ST_FINAL: next_s = ST_DONE;
      ST_DONE: begin
        if (m_valid_r && bus.m_ready) next_s = ST_IDLE;
        else                          next_s = ST_DONE;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they register in step with it
  always_comb begin
    s_ready_nx_s = 1'b0;
    m_valid_nx_s = 1'b0;
    busy_nx_s    = 1'b1;
    case (next_s)
      ST_IDLE: begin
        s_ready_nx_s = 1'b1;
        busy_nx_s    = 1'b0;
      end
      ST_WAIT:  s_ready_nx_s = 1'b1;
      ST_DONE:  m_valid_nx_s = 1'b1;
      default: begin
        s_ready_nx_s = 1'b0;
        m_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      s_ready_r <= s_ready_nx_s;
      m_valid_r <= m_valid_nx_s;
      busy_r    <= busy_nx_s;
    end
  end

  // Datapath: frame configuration, shift register, CRC register and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_r    <= {W{1'b0}};
      poly_r   <= {W{1'b0}};
      xorout_r <= {W{1'b0}};
      refin_r  <= 1'b0;
      refout_r <= 1'b0;
      sh_r     <= {DW{1'b0}};
      last_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      m_crc_r  <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            poly_r   <= cfg_poly;
            xorout_r <= cfg_xorout;
            refin_r  <= cfg_refin;
            refout_r <= cfg_refout;
            crc_r    <= cfg_init;
            sh_r     <= word_s;
            last_r   <= bus.s_last;
            cnt_r    <= {CW{1'b0}};
          end
        end
        ST_WAIT: begin
          if (accept_s) begin
            sh_r   <= word_s;
            last_r <= bus.s_last;
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_SHIFT: begin
          crc_r <= step_crc_s;
          sh_r  <= sh_r << BPC;
          cnt_r <= cnt_r + CW'(1);
        end
        ST_FINAL: m_crc_r <= final_s;
        default: begin
          crc_r <= crc_r;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_crc   = m_crc_r;
  assign busy        = busy_r;

endmodule
